lsu_dmem_adapter: RTL and testbench
===================================

Name: lsu_dmem_adapter

Overview:
Load/store adapter between the rv32 core's memory stage and the word-only data memory (dmem: combinational read, synchronous word write, no byte enables).
- Converts byte-addressed LB/LH/LW/LBU/LHU/SB/SH/SW requests into word accesses.
- Sub-word stores are done as read-modify-write (RMW).
- Registers the response and flags misaligned accesses.

Parameters:
- DATA_LENGTH, 32, data word width; must be 32.
- ADDR_LENGTH, 10, dmem word-address width; dmem holds 2**ADDR_LENGTH words.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  1  core presents a request.
- req_ready  output  1  adapter can accept a request this cycle.
- req_we  input  1  1 = store, 0 = load.
- req_size  input  2  00 byte, 01 half, 10 word, 11 illegal.
- req_unsigned  input  1  loads only: zero-extend when 1, sign-extend when 0.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data; sub-word data is taken from the low bits.
- resp_valid  output  1  one-cycle pulse: request complete.
- resp_rdata  output  32  extended load data; 0 for stores and for errors.
- resp_err  output  1  request was misaligned or illegal (valid only with resp_valid).
- mem_we  output  1  to dmem we.
- mem_addr  output  ADDR_LENGTH  to dmem addr (word index).
- mem_wdata  output  32  to dmem write_data.
- mem_rdata  input  32  from dmem read_data (combinational).

Behaviour:
- Reset is already decided as one clock `clk` and a synchronous, active-high `reset`.
- States: IDLE, WRITE, RESP.
- Reset values: state = IDLE; req_ready = 0 while reset is high; resp_valid = 0, resp_rdata = 0, resp_err = 0, mem_we = 0.
- Handshake: a request is accepted on any rising edge with req_valid & req_ready. req_ready = 1 only in IDLE. There is no resp_ready; the core must wait for resp_valid.
- Word index = req_addr[ADDR_LENGTH+1:2]. Higher address bits are ignored, so addresses wrap modulo 4*2**ADDR_LENGTH.
- In IDLE, mem_addr is driven from req_addr, so mem_rdata shows the old word during the accept cycle.
- Accept with error: go to RESP with resp_err latched to 1; no dmem write.
- Accept a load: extract the byte (addr[1:0]) or half (addr[1]) from mem_rdata, extend it, latch it, go to RESP. Load latency: resp_valid in cycle N+1 for accept in cycle N.
- Accept a store: latch the word index. Latch the merged word: mem_rdata with the selected lane(s) replaced by req_wdata[7:0] or [15:0]; SW replaces all 32 bits. Go to WRITE.
- WRITE: mem_we = 1, mem_addr and mem_wdata come from the latched values, then go to RESP. Store: accept N, write edge at end of N+1, resp_valid in N+2.
- RESP: resp_valid = 1 for exactly one cycle, then IDLE. A new request is accepted in IDLE only, so there is no back-to-back issue: minimum 2 cycles per load, 3 per store.
- Outputs resp_* are registered and change only on state entry.
- Lane mapping is little-endian: byte k is bits [8k+7:8k].
- Reset mid-operation: reset high in WRITE forces mem_we = 0 in that cycle (mem_we gated by ~reset), so the write is dropped. State returns to IDLE at that edge and a pending resp_valid is never issued.
- req inputs are ignored outside IDLE.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined: half with addr[0] = 1, word with addr[1:0] != 0, or size 11 gives resp_err = 1, resp_rdata = 0, and no write.
- Undefined: misaligned addresses are aligned down (half ignores addr[0]; word ignores addr[1:0]) and proceed normally. Size 11 is treated as word. resp_err is tied 0.

Test Plan:
- Reset, preload word 5 = 0x8899AABB, LB at addr 0x15 -> resp_valid one cycle after accept, resp_rdata = 0xFFFFFFAA, resp_err = 0.
- Same word, LHU at addr 0x16, then LH at 0x16 -> 0x00008899, then 0xFFFF8899.
- SB addr 0x15 wdata 0x12345677 -> mem_we high exactly one cycle, word 5 = 0x8899 77 BB (0x889977BB); resp_valid two cycles after accept, resp_rdata = 0.
- SW addr 0x0 wdata 0xDEADBEEF, then LW addr 0x0 -> 0xDEADBEEF. Address 0x1000 (ADDR_LENGTH = 10) wraps to word 0, so LW returns the same value.
- Reset asserted during WRITE of SH 0xCAFE to word 3 (old 0x11223344) -> word 3 unchanged, no resp_valid, req_ready = 1 on the first cycle after reset drops.
- With LSU_MISALIGN_TRAP_EN: LW at addr 0x6 -> resp_err = 1, resp_rdata = 0, no write. Without the macro: same access returns word 1, resp_err = 0.

Source files
------------

// File: rtl/lsu_dmem_adapter.sv
// lsu_dmem_adapter
// Load/store adapter between the rv32 memory stage and a word-only data
// memory (combinational read, synchronous word write, no byte enables).
// Byte/half/word loads are extracted and extended from the addressed word;
// sub-word stores are done as read-modify-write.
//
// Ports:
//   clk, reset        clock and synchronous active-high reset
//   req_valid/ready   request handshake (ready only in IDLE)
//   req_we            1 = store, 0 = load
//   req_size          00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned      loads: zero-extend when 1, sign-extend when 0
//   req_addr          byte address
//   req_wdata         store data (sub-word data taken from the low bits)
//   resp_valid        one-cycle completion pulse
//   resp_rdata        extended load data, 0 for stores and errors
//   resp_err          misaligned/illegal request flag
//   mem_we/addr/wdata to dmem
//   mem_rdata         from dmem (combinational)
//
// Build option: define LSU_MISALIGN_TRAP_EN to report misaligned halves/words
// and size 11 as errors. Without it, misaligned addresses are aligned down,
// size 11 behaves as a word and resp_err stays 0.

module lsu_dmem_adapter #(
  parameter int DATA_LENGTH = 32,
  parameter int ADDR_LENGTH = 10
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_we,
  input  logic [1:0]             req_size,
  input  logic                   req_unsigned,
  input  logic [31:0]            req_addr,
  input  logic [DATA_LENGTH-1:0] req_wdata,
  output logic                   resp_valid,
  output logic [DATA_LENGTH-1:0] resp_rdata,
  output logic                   resp_err,
  output logic                   mem_we,
  output logic [ADDR_LENGTH-1:0] mem_addr,
  output logic [DATA_LENGTH-1:0] mem_wdata,
  input  logic [DATA_LENGTH-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, WRITE, RESP} state_t;

  state_t                 state;
  logic [ADDR_LENGTH-1:0] addr_q;
  logic [DATA_LENGTH-1:0] wdata_q;

  logic [ADDR_LENGTH-1:0] req_index;
  logic [1:0]             size_eff;
  logic                   req_err;
  logic [7:0]             byte_sel;
  logic [15:0]            half_sel;
  logic [DATA_LENGTH-1:0] load_data;
  logic [DATA_LENGTH-1:0] merged_word;

  // Address bits above the dmem index are deliberately ignored (wrap-around).
  logic unused_addr_bits;
  assign unused_addr_bits = ^req_addr[31:ADDR_LENGTH+2];

  assign req_index = req_addr[ADDR_LENGTH+1:2];
  // Size 11 only reaches the datapath as a word when it is not trapped.
  assign size_eff  = (req_size == 2'b11) ? 2'b10 : req_size;

`ifdef LSU_MISALIGN_TRAP_EN
  assign req_err = (req_size == 2'b11) ||
                   ((req_size == 2'b01) && req_addr[0]) ||
                   ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
`else
  assign req_err = 1'b0;
`endif

  assign req_ready = (state == IDLE) && !reset;
  // Gating with reset drops a write that is in flight when reset arrives.
  assign mem_we    = (state == WRITE) && !reset;
  // In IDLE the memory is addressed straight from the request so the old
  // word is visible during the accept cycle.
  assign mem_addr  = (state == IDLE) ? req_index : addr_q;
  assign mem_wdata = wdata_q;

  // Lane extraction/extension for loads and lane merge for sub-word stores,
  // both working on the word currently on mem_rdata (little-endian lanes).
  always_comb begin
    byte_sel    = mem_rdata[8*req_addr[1:0] +: 8];
    half_sel    = req_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    load_data   = mem_rdata;
    merged_word = mem_rdata;
    case (size_eff)
      2'b00: begin
        load_data = {{24{~req_unsigned & byte_sel[7]}}, byte_sel};
        merged_word[8*req_addr[1:0] +: 8] = req_wdata[7:0];
      end
      2'b01: begin
        load_data = {{16{~req_unsigned & half_sel[15]}}, half_sel};
        if (req_addr[1]) merged_word[31:16] = req_wdata[15:0];
        else             merged_word[15:0]  = req_wdata[15:0];
      end
      default: begin
        load_data   = mem_rdata;
        merged_word = req_wdata;
      end
    endcase
  end

  // Control FSM; the response outputs are registered and only change when a
  // state is entered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            addr_q  <= req_index;
            wdata_q <= merged_word;
            if (req_err) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_rdata <= '0;
              resp_err   <= 1'b1;
            end else if (req_we) begin
              state <= WRITE;
            end else begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_rdata <= load_data;
              resp_err   <= 1'b0;
            end
          end
        end
        WRITE: begin
          state      <= RESP;
          resp_valid <= 1'b1;
          resp_rdata <= '0;
          resp_err   <= 1'b0;
        end
        RESP: begin
          state      <= IDLE;
          resp_valid <= 1'b0;
          resp_rdata <= '0;
          resp_err   <= 1'b0;
        end
        default: begin
          state      <= IDLE;
          resp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_dmem_adapter.sv
// Directed testbench for lsu_dmem_adapter with a behavioural word memory.
// Inputs are driven and outputs sampled around the falling clock edge.

module tb_lsu_dmem_adapter;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] mem [1024];
  logic        pre_we;
  logic [9:0]  pre_addr;
  logic [31:0] pre_data;

  int checks;
  int failures;

  lsu_dmem_adapter #(.DATA_LENGTH(32), .ADDR_LENGTH(10)) dut (
    .clk(clk),
    .reset(reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we(req_we),
    .req_size(req_size),
    .req_unsigned(req_unsigned),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid),
    .resp_rdata(resp_rdata),
    .resp_err(resp_err),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word memory: combinational read, synchronous write, plus a preload port
  // used only while the adapter is held in reset.
  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (pre_we) mem[pre_addr] <= pre_data;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $display("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
      $error("[TB] %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic we, input logic [1:0] size,
                               input logic uns, input logic [31:0] addr,
                               input logic [31:0] wdata);
    req_valid    = valid;
    req_we       = we;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
  endtask

  task automatic preload(input logic [9:0] idx, input logic [31:0] data);
    @(negedge clk);
    pre_we   = 1'b1;
    pre_addr = idx;
    pre_data = data;
    @(negedge clk);
    pre_we   = 1'b0;
  endtask

  // Load: accept on the next rising edge, response one cycle later.
  task automatic doLoad(input string tag, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] expData,
                        input logic expErr);
    applyStimulus(1'b1, 1'b0, size, uns, addr, 32'h0);
    #1 checkOutput({tag, ".ready"}, {31'b0, req_ready}, 32'h1);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    checkOutput({tag, ".valid"}, {31'b0, resp_valid}, 32'h1);
    checkOutput({tag, ".rdata"}, resp_rdata, expData);
    checkOutput({tag, ".err"}, {31'b0, resp_err}, {31'b0, expErr});
    checkOutput({tag, ".we"}, {31'b0, mem_we}, 32'h0);
    @(negedge clk);
    checkOutput({tag, ".pulse"}, {31'b0, resp_valid}, 32'h0);
  endtask

  // Store: write cycle after accept, response the cycle after that.
  task automatic doStore(input string tag, input logic [1:0] size, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [9:0] idx,
                         input logic [31:0] expWord);
    applyStimulus(1'b1, 1'b1, size, 1'b0, addr, wdata);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    checkOutput({tag, ".we"}, {31'b0, mem_we}, 32'h1);
    checkOutput({tag, ".addr"}, {22'b0, mem_addr}, {22'b0, idx});
    checkOutput({tag, ".wdata"}, mem_wdata, expWord);
    checkOutput({tag, ".early"}, {31'b0, resp_valid}, 32'h0);
    @(negedge clk);
    checkOutput({tag, ".we_off"}, {31'b0, mem_we}, 32'h0);
    checkOutput({tag, ".valid"}, {31'b0, resp_valid}, 32'h1);
    checkOutput({tag, ".rdata"}, resp_rdata, 32'h0);
    checkOutput({tag, ".mem"}, mem[idx], expWord);
    @(negedge clk);
    checkOutput({tag, ".pulse"}, {31'b0, resp_valid}, 32'h0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    pre_we   = 1'b0;
    pre_addr = '0;
    pre_data = '0;
    reset    = 1'b1;
    applyStimulus(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);

    preload(10'd0, 32'h0000_0000);
    preload(10'd1, 32'h5566_7788);
    preload(10'd3, 32'h1122_3344);
    preload(10'd5, 32'h8899_AABB);

    @(negedge clk);
    checkOutput("rst.ready", {31'b0, req_ready}, 32'h0);
    checkOutput("rst.valid", {31'b0, resp_valid}, 32'h0);
    checkOutput("rst.rdata", resp_rdata, 32'h0);
    checkOutput("rst.err", {31'b0, resp_err}, 32'h0);
    checkOutput("rst.we", {31'b0, mem_we}, 32'h0);
    reset = 1'b0;

    doLoad("lb15",  2'b00, 1'b0, 32'h15, 32'hFFFF_FFAA, 1'b0);
    doLoad("lhu16", 2'b01, 1'b1, 32'h16, 32'h0000_8899, 1'b0);
    doLoad("lh16",  2'b01, 1'b0, 32'h16, 32'hFFFF_8899, 1'b0);
    doLoad("lbu14", 2'b00, 1'b1, 32'h14, 32'h0000_00BB, 1'b0);

    doStore("sb15", 2'b00, 32'h15, 32'h1234_5677, 10'd5, 32'h8899_77BB);
    doLoad("lw14",  2'b10, 1'b0, 32'h14, 32'h8899_77BB, 1'b0);
    doStore("sh16", 2'b01, 32'h16, 32'h1234_CAFE, 10'd5, 32'hCAFE_77BB);
    doLoad("lb17",  2'b00, 1'b0, 32'h17, 32'hFFFF_FFCA, 1'b0);

    doStore("sw0",  2'b10, 32'h0, 32'hDEAD_BEEF, 10'd0, 32'hDEAD_BEEF);
    doLoad("lw0",   2'b10, 1'b0, 32'h0, 32'hDEAD_BEEF, 1'b0);
    doLoad("lw1000", 2'b10, 1'b0, 32'h1000, 32'hDEAD_BEEF, 1'b0);

`ifdef LSU_MISALIGN_TRAP_EN
    doLoad("lw6",   2'b10, 1'b0, 32'h6, 32'h0, 1'b1);
    doLoad("sz11",  2'b11, 1'b0, 32'h4, 32'h0, 1'b1);
    doLoad("lh5",   2'b01, 1'b0, 32'h5, 32'h0, 1'b1);
`else
    doLoad("lw6",   2'b10, 1'b0, 32'h6, 32'h5566_7788, 1'b0);
    doLoad("sz11",  2'b11, 1'b0, 32'h4, 32'h5566_7788, 1'b0);
    doLoad("lh5",   2'b01, 1'b0, 32'h5, 32'h0000_7788, 1'b0);
`endif
    checkOutput("mis.mem1", mem[1], 32'h5566_7788);

    // Reset arriving while the SH write is pending must drop the write.
    applyStimulus(1'b1, 1'b1, 2'b01, 1'b0, 32'hC, 32'h0000_CAFE);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    checkOutput("rw.we_pre", {31'b0, mem_we}, 32'h1);
    reset = 1'b1;
    #1 checkOutput("rw.we_gated", {31'b0, mem_we}, 32'h0);
    checkOutput("rw.ready_rst", {31'b0, req_ready}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    #1 checkOutput("rw.ready", {31'b0, req_ready}, 32'h1);
    checkOutput("rw.valid", {31'b0, resp_valid}, 32'h0);
    checkOutput("rw.mem3", mem[3], 32'h1122_3344);
    @(negedge clk);
    checkOutput("rw.valid2", {31'b0, resp_valid}, 32'h0);
    doLoad("lw3", 2'b10, 1'b0, 32'hC, 32'h1122_3344, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
